// File: rtl/ddma_cmd_scheduler_if.sv
// ddma_cmd_scheduler_if: command bundle between the scheduler and the DMA engine.
// The scheduler is the master; the engine drives busy/done back.
interface ddma_cmd_scheduler_if #(
  parameter int AW = 30,
  parameter int CW = 3
);
  logic [AW-1:0] dma_addr;
  logic [AW-1:0] dma_nbytes;
  logic [CW-1:0] dma_chan;
  logic          dma_start;
  logic          dma_busy;
  logic          dma_done;

  modport master (
    output dma_addr, dma_nbytes, dma_chan, dma_start,
    input  dma_busy, dma_done
  );

  modport slave (
    input  dma_addr, dma_nbytes, dma_chan, dma_start,
    output dma_busy, dma_done
  );
endinterface

// File: rtl/ddma_cmd_scheduler.sv
// ddma_cmd_scheduler: N-channel edge-captured DMA command queue and dispatcher.
// Optional DDMA_TRACE_EN prints accepted edges and completions in simulation.
module ddma_cmd_scheduler #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int NUM_CHANNELS = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH = 32,
  parameter int ADDRESS = 0,
  localparam int AW = MEMORY_BUS_WIDTH - 2,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CHANNELS*AW-1:0] ch_addr_in,
  input  logic [NUM_CHANNELS*AW-1:0] ch_nbytes_in,
  input  logic [NUM_CHANNELS-1:0]    ch_cmd_in,
  input  logic [NUM_CHANNELS-1:0]    ch_irq_ack,
  output logic [NUM_CHANNELS-1:0]    status_out,
  output logic [NUM_CHANNELS-1:0]    irq_out,
  output logic [NUM_CHANNELS-1:0]    err_out,
  ddma_cmd_scheduler_if.master       dma,
  output logic                       latency_valid,
  output logic [TS_WIDTH-1:0]        latency_out,
  output logic [CW-1:0]              latency_chan
);
  localparam int N  = NUM_CHANNELS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  typedef struct packed {
    logic [CW-1:0]       chan;
    logic [AW-1:0]       addr;
    logic [AW-1:0]       nbytes;
    logic [TS_WIDTH-1:0] ts;
  } cmd_t;

  logic [TS_WIDTH-1:0] cnt;
  logic [N-1:0]        cmd_q;
  logic [N-1:0]        edge_hit;
  logic [N-1:0]        accept;
  logic [N-1:0]        reject;
  logic [N-1:0]        pend;
  logic [N-1:0]        done_mask;
  logic [AW-1:0]       p_addr [N];
  logic [AW-1:0]       p_nb   [N];
  logic [TS_WIDTH-1:0] p_ts   [N];

  cmd_t          fifo [FIFO_DEPTH];
  cmd_t          ent;
  cmd_t          head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [CW-1:0] rr;
  logic [CW-1:0] gnt;
  logic          gnt_ok;

  logic [1:0]          state;
  logic [CW-1:0]       fly_chan;
  logic [TS_WIDTH-1:0] fly_ts;
  logic                done_hit;

  assign edge_hit = ch_cmd_in & ~cmd_q;
  assign accept   = edge_hit & ~status_out;
  assign reject   = edge_hit & status_out;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = fifo[rptr];
  assign pop   = (state == S_ISSUE);
  // a full FIFO still takes a push when the head leaves this cycle
  assign push  = gnt_ok & (~full | pop);

  assign done_hit = (state == S_WAIT) & dma.dma_done;

  assign dma.dma_start  = pop;
  assign dma.dma_addr   = pop ? head.addr   : '0;
  assign dma.dma_nbytes = pop ? head.nbytes : '0;
  assign dma.dma_chan   = pop ? head.chan   : '0;

  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gnt_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr) + k) % N;
      if (!gnt_ok && pend[idx]) begin
        gnt_ok = 1'b1;
        gnt    = CW'(idx);
      end
    end
  end

  always_comb begin
    ent      = '0;
    ent.chan = gnt;
    for (int i = 0; i < N; i++) begin
      if (gnt == CW'(i)) begin
        ent.addr   = p_addr[i];
        ent.nbytes = p_nb[i];
        ent.ts     = p_ts[i];
      end
    end
  end

  always_comb begin
    done_mask = '0;
    for (int i = 0; i < N; i++)
      done_mask[i] = done_hit && (fly_chan == CW'(i));
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        p_addr[i] <= ch_addr_in[i*AW +: AW];
        p_nb[i]   <= ch_nbytes_in[i*AW +: AW];
        p_ts[i]   <= cnt;
      end
    end
    if (push)
      fifo[wptr] <= ent;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt           <= '0;
      cmd_q         <= '0;
      pend          <= '0;
      status_out    <= '0;
      irq_out       <= '0;
      err_out       <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      rr            <= '0;
      state         <= S_IDLE;
      fly_chan      <= '0;
      fly_ts        <= '0;
      latency_valid <= 1'b0;
      latency_out   <= '0;
      latency_chan  <= '0;
    end else begin
      cnt        <= cnt + 1'b1;
      cmd_q      <= ch_cmd_in;
      status_out <= (status_out | accept) & ~done_mask;
      irq_out    <= (irq_out & ~ch_irq_ack) | done_mask;
      err_out    <= err_out | reject;

      for (int i = 0; i < N; i++) begin
        if (accept[i])
          pend[i] <= 1'b1;
        else if (push && gnt == CW'(i))
          pend[i] <= 1'b0;
      end

      if (push) begin
        wptr <= wptr + 1'b1;
        rr   <= (gnt == CW'(N-1)) ? '0 : gnt + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (!empty && !dma.dma_busy)
            state <= S_ISSUE;
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          fly_chan <= head.chan;
          fly_ts   <= head.ts;
        end
        S_WAIT: begin
          if (dma.dma_done)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      latency_valid <= done_hit;
      if (done_hit) begin
        latency_out  <= cnt - fly_ts;
        latency_chan <= fly_chan;
      end
    end
  end

`ifdef DDMA_TRACE_EN
  logic [AW-1:0] fly_nb;

  always_ff @(posedge clock) begin
    if (!reset)
      fly_nb <= '0;
    else if (pop)
      fly_nb <= head.nbytes;
  end

  always @(posedge clock) begin
    if (reset && ADDRESS == 0) begin
      for (int i = 0; i < N; i++)
        if (accept[i])
          $display("ddma edge ch=%0d t=%0d nbytes=%0d",
                   i, cnt, ch_nbytes_in[i*AW +: AW]);
      if (done_hit)
        $display("ddma done ch=%0d t=%0d nbytes=%0d",
                 fly_chan, cnt, fly_nb);
    end
  end
`endif

endmodule
